// File: rtl/h264_bitsched.sv
// h264_bitsched: slice-level bitstream scheduler feeding the byte packer.
// Orders header words before CAVLC words per macroblock, tracks the bit
// position modulo 8 and appends the RBSP trailing bits at slice end.
// Optional feature: define BITSCHED_BITCOUNT_EN to enable the SLICEBITS counter.
module h264_bitsched #(
  parameter int VEW  = 25,
  parameter int HVEW = 20
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            NEWSLICE,
  input  logic            ENDSLICE,
  input  logic            HVALID,
  input  logic [HVEW-1:0] HVE,
  input  logic [4:0]      HVL,
  input  logic            HLAST,
  output logic            HREADY,
  input  logic            CVALID,
  input  logic [VEW-1:0]  CVE,
  input  logic [4:0]      CVL,
  input  logic            CLAST,
  output logic            CREADY,
  output logic            VALID,
  output logic [VEW-1:0]  VE,
  output logic [4:0]      VL,
  input  logic            READY,
  output logic            BUSY,
  output logic            DONE,
  output logic [31:0]     SLICEBITS
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_COEF,
    S_ALIGN,
    S_FLUSH
  } state_t;

  state_t           r_state;
  logic             r_valid;
  logic [VEW-1:0]   r_ve;
  logic [4:0]       r_vl;
  logic [2:0]       r_bitpos;
  logic             r_endpend;
  logic             r_hdr_any;
  logic             r_done;

  logic             w_slot_free;
  logic             w_hacc;
  logic             w_cacc;
  logic [3:0]       w_trail_vl;
  logic [VEW-1:0]   w_trail_ve;
  logic             w_load;
  logic [VEW-1:0]   w_ld_ve;
  logic [4:0]       w_ld_vl;

  assign w_slot_free = !r_valid || READY;
  assign w_hacc      = (r_state == S_HDR)  && w_slot_free && HVALID;
  assign w_cacc      = (r_state == S_COEF) && w_slot_free && CVALID;
  assign w_trail_vl  = 4'd8 - {1'b0, r_bitpos};
  assign w_trail_ve  = {{(VEW-1){1'b0}}, 1'b1} << (w_trail_vl - 4'd1);

  assign HREADY = (r_state == S_HDR)  && w_slot_free;
  assign CREADY = (r_state == S_COEF) && w_slot_free;
  assign VALID  = r_valid;
  assign VE     = r_ve;
  assign VL     = r_vl;
  assign BUSY   = (r_state != S_IDLE);
  assign DONE   = r_done;

  // Select the word to load into the output slot; zero-length words are dropped
  always_comb begin
    w_load  = 1'b0;
    w_ld_ve = '0;
    w_ld_vl = '0;
    if (w_hacc && (HVL != '0)) begin
      w_load  = 1'b1;
      w_ld_ve = {{(VEW-HVEW){1'b0}}, HVE};
      w_ld_vl = HVL;
    end else if (w_cacc && (CVL != '0)) begin
      w_load  = 1'b1;
      w_ld_ve = CVE;
      w_ld_vl = CVL;
    end else if ((r_state == S_ALIGN) && w_slot_free) begin
      w_load  = 1'b1;
      w_ld_ve = w_trail_ve;
      w_ld_vl = {1'b0, w_trail_vl};
    end
  end

  // One-entry output buffer towards the packer
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_valid <= 1'b0;
      r_ve    <= '0;
      r_vl    <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_ve    <= w_ld_ve;
      r_vl    <= w_ld_vl;
    end else if (READY) begin
      r_valid <= 1'b0;
    end
  end

  // Slice sequencing FSM with bit-position and end-request tracking
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_bitpos  <= '0;
      r_endpend <= 1'b0;
      r_hdr_any <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load)
        r_bitpos <= r_bitpos + w_ld_vl[2:0];
      case (r_state)
        S_IDLE: begin
          if (NEWSLICE) begin
            r_state   <= S_HDR;
            r_bitpos  <= '0;
            r_endpend <= ENDSLICE;
            r_hdr_any <= 1'b0;
          end
        end
        S_HDR: begin
          // An offered header word is taken even when an end request is
          // pending, so nothing handed over on HREADY is ever dropped.
          if (w_hacc) begin
            if (ENDSLICE)
              r_endpend <= 1'b1;
            if (HLAST) begin
              r_state   <= S_COEF;
              r_hdr_any <= 1'b0;
            end else begin
              r_hdr_any <= 1'b1;
            end
          end else if (!r_hdr_any && (ENDSLICE || r_endpend)) begin
            r_state <= S_ALIGN;
          end else if (ENDSLICE) begin
            r_endpend <= 1'b1;
          end
        end
        S_COEF: begin
          // ENDSLICE coincident with CLAST terminates right away rather than
          // detouring through HDR, where a queued header could slip in.
          if (w_cacc && CLAST) begin
            if (r_endpend || ENDSLICE)
              r_state <= S_ALIGN;
            else
              r_state <= S_HDR;
          end else if (ENDSLICE) begin
            r_endpend <= 1'b1;
          end
        end
        S_ALIGN: begin
          if (w_slot_free)
            r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (r_valid && READY) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef BITSCHED_BITCOUNT_EN
  logic [31:0] r_bits;
  logic [32:0] w_bits_sum;

  assign w_bits_sum = {1'b0, r_bits} + {28'd0, w_ld_vl};
  assign SLICEBITS  = r_bits;

  // Saturating count of all loaded bits in the current slice
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      r_bits <= '0;
    else if ((r_state == S_IDLE) && NEWSLICE)
      r_bits <= '0;
    else if (w_load)
      r_bits <= w_bits_sum[32] ? '1 : w_bits_sum[31:0];
  end
`else
  assign SLICEBITS = '0;
`endif

endmodule

// File: tb/tb_h264_bitsched.sv
// Self-checking bench for h264_bitsched: directed steps plus randomized
// slices, checked against a scoreboard of expected packer words.
module tb_h264_bitsched;

  localparam int VEW  = 25;
  localparam int HVEW = 20;

  logic            CLK = 1'b0;
  logic            RESET;
  logic            NEWSLICE, ENDSLICE;
  logic            HVALID, HLAST, HREADY;
  logic [HVEW-1:0] HVE;
  logic [4:0]      HVL;
  logic            CVALID, CLAST, CREADY;
  logic [VEW-1:0]  CVE;
  logic [4:0]      CVL;
  logic            VALID, READY, BUSY, DONE;
  logic [VEW-1:0]  VE;
  logic [4:0]      VL;
  logic [31:0]     SLICEBITS;

  h264_bitsched #(.VEW(VEW), .HVEW(HVEW)) dut (
    .CLK(CLK), .RESET(RESET), .NEWSLICE(NEWSLICE), .ENDSLICE(ENDSLICE),
    .HVALID(HVALID), .HVE(HVE), .HVL(HVL), .HLAST(HLAST), .HREADY(HREADY),
    .CVALID(CVALID), .CVE(CVE), .CVL(CVL), .CLAST(CLAST), .CREADY(CREADY),
    .VALID(VALID), .VE(VE), .VL(VL), .READY(READY), .BUSY(BUSY), .DONE(DONE),
    .SLICEBITS(SLICEBITS)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [VEW-1:0] ve;
    logic [4:0]     vl;
    bit             trail;
  } ent_t;

  int              checks = 0;
  int              errors = 0;
  ent_t            expq[$];
  longint unsigned m_total;
  int              rdy_mode = 0;
  bit              mon_en = 0;
  bit              exp_done = 0;
  bit              prev_hold = 0;
  logic [VEW-1:0]  prev_ve;
  logic [4:0]      prev_vl;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: stream of words in protocol order plus slice bit total
  task automatic exp_word(input logic [VEW-1:0] ve, input logic [4:0] vl);
    ent_t e;
    if (vl != 0) begin
      e.ve = ve; e.vl = vl; e.trail = 0;
      expq.push_back(e);
    end
    m_total += vl;
  endtask

  task automatic exp_trail();
    ent_t e;
    int   v;
    v = 8 - int'(m_total % 8);
    e.ve = 25'd1 << (v - 1);
    e.vl = 5'(v);
    e.trail = 1;
    expq.push_back(e);
    m_total += longint'(v);
  endtask

  function automatic logic [31:0] exp_bits();
`ifdef BITSCHED_BITCOUNT_EN
    return (m_total > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_total);
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [4:0] rand_vl();
    if ($urandom_range(0, 7) == 0) return 5'd0;
    return 5'($urandom_range(1, 31));
  endfunction

  // Packer-side READY driver
  always @(posedge CLK) begin
    #1;
    case (rdy_mode)
      0:       READY = 1'b1;
      1:       READY = ($urandom_range(0, 3) != 0);
      default: READY = 1'b0;
    endcase
  end

  // Output monitor / scoreboard
  always @(negedge CLK) begin
    if (mon_en) begin
      ent_t e;
      chk("ready_excl", HREADY & CREADY, 0);
      chk("done", DONE, exp_done);
      exp_done = 0;
      if (prev_hold) begin
        chk("hold_valid", VALID, 1);
        chk("hold_ve", VE, prev_ve);
        chk("hold_vl", VL, prev_vl);
      end
      prev_hold = VALID && !READY;
      prev_ve = VE;
      prev_vl = VL;
      if (VALID && READY) begin
        if (expq.size() == 0) begin
          chk("spurious_word", VALID, 0);
        end else begin
          e = expq.pop_front();
          chk("out_ve", VE, e.ve);
          chk("out_vl", VL, e.vl);
          if (e.trail) exp_done = 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic send_h(input logic [HVEW-1:0] ve, input logic [4:0] vl, input bit last);
    int n = 0;
    HVALID = 1; HVE = ve; HVL = vl; HLAST = last;
    do begin @(negedge CLK); n++; end while (HREADY !== 1'b1 && n < 2000);
    if (HREADY !== 1'b1) chk("hready_timeout", HREADY, 1);
    step();
    HVALID = 0; HLAST = 0;
  endtask

  task automatic send_c(input logic [VEW-1:0] ve, input logic [4:0] vl, input bit last);
    int n = 0;
    CVALID = 1; CVE = ve; CVL = vl; CLAST = last;
    do begin @(negedge CLK); n++; end while (CREADY !== 1'b1 && n < 2000);
    if (CREADY !== 1'b1) chk("cready_timeout", CREADY, 1);
    step();
    CVALID = 0; CLAST = 0;
  endtask

  task automatic start_slice(input bit with_end);
    NEWSLICE = 1; ENDSLICE = with_end; m_total = 0;
    step();
    NEWSLICE = 0; ENDSLICE = 0;
  endtask

  task automatic pulse_end();
    ENDSLICE = 1;
    step();
    ENDSLICE = 0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (DONE === 1'b1) break;
    end
    chk("done_seen", DONE, 1);
    chk("slicebits", SLICEBITS, exp_bits());
    chk("busy_idle", BUSY, 0);
    chk("words_left", expq.size(), 0);
    step();
  endtask

  task automatic run_mb(input int nh, input int nc, input bit mid_end);
    logic [HVEW-1:0] hv[$];
    logic [4:0]      hl[$];
    logic [VEW-1:0]  cv[$];
    logic [4:0]      cl[$];
    for (int i = 0; i < nh; i++) begin
      hv.push_back(20'($urandom));
      hl.push_back(rand_vl());
      exp_word({5'd0, hv[i]}, hl[i]);
    end
    for (int i = 0; i < nc; i++) begin
      cv.push_back(25'($urandom));
      cl.push_back(rand_vl());
      exp_word(cv[i], cl[i]);
    end
    fork
      begin
        for (int i = 0; i < nh; i++) send_h(hv[i], hl[i], i == nh - 1);
      end
      begin
        for (int i = 0; i < nc; i++) begin
          send_c(cv[i], cl[i], i == nc - 1);
          if (mid_end && i == 0 && nc > 1) pulse_end();
        end
      end
    join
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [HVEW-1:0] hv0, hv1, hv2;
    logic [VEW-1:0]  cv0;
    int              nmb, nc;
    bit              mid;

    RESET = 1; NEWSLICE = 0; ENDSLICE = 0;
    HVALID = 0; HVE = '0; HVL = '0; HLAST = 0;
    CVALID = 0; CVE = '0; CVL = '0; CLAST = 0;
    READY = 1; m_total = 0;
    repeat (2) @(negedge CLK);

    // Reset state
    chk("rst_valid", VALID, 0);
    chk("rst_ve", VE, 0);
    chk("rst_vl", VL, 0);
    chk("rst_hready", HREADY, 0);
    chk("rst_cready", CREADY, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_slicebits", SLICEBITS, 0);
    step();
    RESET = 0;
    step();
    mon_en = 1;

    // Basic slice: 5,3 | 9 then end -> trailing 0x40/7, 24 bits
    start_slice(0);
    chk("busy_hdr", BUSY, 1);
    exp_word(25'h15, 5); exp_word(25'h5, 3); exp_word(25'h1AB, 9);
    send_h(20'h15, 5, 0);
    send_h(20'h5, 3, 1);
    send_c(25'h1AB, 9, 1);
    pulse_end();
    exp_trail();
    wait_done();

    // Ordering: CAVLC waits during HDR, header waits during COEF
    start_slice(0);
    exp_word(25'h11, 5); exp_word(25'h22, 6); exp_word(25'h33, 7);
    exp_word(25'h3, 3); exp_word(25'h9, 4);
    CVALID = 1; CVE = 25'h22; CVL = 6; CLAST = 0;
    repeat (3) begin @(negedge CLK); chk("cready_in_hdr", CREADY, 0); end
    step();
    send_h(20'h11, 5, 1);
    send_c(25'h22, 6, 0);
    HVALID = 1; HVE = 20'h3; HVL = 3; HLAST = 1;
    repeat (3) begin @(negedge CLK); chk("hready_in_coef", HREADY, 0); end
    step();
    fork
      send_h(20'h3, 3, 1);
      send_c(25'h33, 7, 1);
    join
    send_c(25'h9, 4, 1);
    pulse_end();
    exp_trail();
    wait_done();

    // Backpressure: READY low for 10 cycles holds the first word
    rdy_mode = 2; step(); step();
    start_slice(0);
    hv0 = 20'($urandom); hv1 = 20'($urandom); hv2 = 20'($urandom); cv0 = 25'($urandom);
    exp_word({5'd0, hv0}, 7); exp_word({5'd0, hv1}, 12);
    exp_word({5'd0, hv2}, 6); exp_word(cv0, 11);
    fork
      begin
        send_h(hv0, 7, 0); send_h(hv1, 12, 0); send_h(hv2, 6, 1);
        send_c(cv0, 11, 1);
      end
      begin
        repeat (2) @(negedge CLK);
        for (int i = 0; i < 10; i++) begin
          @(negedge CLK);
          chk("bp_valid", VALID, 1);
          chk("bp_hready", HREADY, 0);
          chk("bp_ve", VE, {5'd0, hv0});
          chk("bp_vl", VL, 7);
        end
        rdy_mode = 0;
      end
    join
    pulse_end();
    exp_trail();
    wait_done();

    // ENDSLICE mid-COEF: 4 | 3 (end) 9 -> 16 bits, trailing 0x80/8
    start_slice(0);
    exp_word(25'hA, 4); exp_word(25'h5, 3); exp_word(25'h1F0, 9);
    send_h(20'hA, 4, 1);
    send_c(25'h5, 3, 0);
    pulse_end();
    send_c(25'h1F0, 9, 1);
    exp_trail();
    wait_done();

    // Zero-length header word with HLAST: no output, moves to COEF
    start_slice(0);
    exp_word(25'h7, 0);
    send_h(20'h7, 0, 1);
    repeat (3) begin @(negedge CLK); chk("vl0_no_valid", VALID, 0); end
    chk("vl0_in_coef", CREADY, 1);
    step();
    exp_word(25'h2A, 6);
    send_c(25'h2A, 6, 1);
    pulse_end();
    exp_trail();
    wait_done();

    // NEWSLICE with ENDSLICE: empty slice, trailing 0x80/8
    start_slice(1);
    exp_trail();
    wait_done();

    // HLAST acceptance coincident with ENDSLICE: slice ends after CLAST
    start_slice(0);
    exp_word(25'h9, 4); exp_word(25'h13, 5);
    fork
      send_h(20'h9, 4, 1);
      pulse_end();
    join
    send_c(25'h13, 5, 1);
    exp_trail();
    wait_done();

    // Randomized slices with random backpressure
    for (int s = 0; s < 20; s++) begin
      rdy_mode = int'($urandom_range(0, 1));
      nmb = int'($urandom_range(1, 3));
      mid = ($urandom_range(0, 1) == 1);
      start_slice(0);
      for (int m = 0; m < nmb; m++) begin
        nc = (mid && m == nmb - 1) ? int'($urandom_range(2, 4)) : int'($urandom_range(1, 4));
        run_mb(int'($urandom_range(1, 3)), nc, mid && m == nmb - 1);
      end
      if (!mid) pulse_end();
      exp_trail();
      wait_done();
    end
    rdy_mode = 0; step();

    // Asynchronous reset while a word is held in COEF
    rdy_mode = 2; step(); step();
    start_slice(0);
    send_h(20'h3, 2, 1);
    chk("pre_rst_valid", VALID, 1);
    chk("pre_rst_busy", BUSY, 1);
    mon_en = 0;
    RESET = 1;
    #1;
    chk("arst_valid", VALID, 0);
    chk("arst_busy", BUSY, 0);
    chk("arst_vl", VL, 0);
    chk("arst_cready", CREADY, 0);
    step();
    RESET = 0;
    expq.delete(); prev_hold = 0; exp_done = 0; rdy_mode = 0;
    step(); step();
    mon_en = 1;
    start_slice(0);
    exp_word(25'h5, 3); exp_word(25'h1, 2);
    send_h(20'h5, 3, 1);
    send_c(25'h1, 2, 1);
    pulse_end();
    exp_trail();
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/h264_bitsched.md
Name: h264_bitsched

Overview:
- Slice-level bitstream scheduler that owns the single VE/VL input of the byte packer.
- Sequences macroblock header words and CAVLC coefficient words in strict per-macroblock order: header first, then coefficients.
- Tracks the bit position modulo 8 and emits the RBSP trailing bits at slice end.
- Replaces the ad-hoc header/cavlc/align priority mux in the encoder top.

Parameters:
- VEW, 25, width of output VE bus; header VE is zero-extended to this width.
- HVEW, 20, width of header VE input.

Ports:
- CLK  in  1  single clock
- RESET  in  1  asynchronous, active-high reset
- NEWSLICE  in  1  one-cycle pulse, starts a slice
- ENDSLICE  in  1  one-cycle pulse, requests slice termination
- HVALID  in  1  header word valid
- HVE  in  HVEW  header codeword, right-aligned
- HVL  in  5  header codeword length in bits
- HLAST  in  1  marks the last header word of the current MB
- HREADY  out  1  header word accepted when HVALID&&HREADY
- CVALID  in  1  cavlc word valid
- CVE  in  VEW  cavlc codeword, right-aligned
- CVL  in  5  cavlc codeword length
- CLAST  in  1  marks the last cavlc word of the current MB
- CREADY  out  1  cavlc word accepted when CVALID&&CREADY
- VALID  out  1  output word valid, to packer
- VE  out  VEW  output codeword
- VL  out  5  output length
- READY  in  1  packer ready; transfer occurs when VALID&&READY
- BUSY  out  1  high in any state other than IDLE
- DONE  out  1  one-cycle pulse when the trailing word is accepted downstream
- SLICEBITS  out  32  bit count (optional feature)

Behaviour:
- Reset values: VALID=0, VE=0, VL=0, HREADY=0, CREADY=0, BUSY=0, DONE=0, SLICEBITS=0, state=IDLE, bitpos=0, endpend=0.
- Output stage is one register (1-entry buffer). slot_free = !VALID || READY.
- Latency: a word accepted in cycle n appears on VE/VL with VALID=1 in cycle n+1.
- Output is held stable while VALID&&!READY.
- HREADY = (state==HDR) && slot_free.
- CREADY = (state==COEF) && slot_free. The two are never both high.
- Words with VL=0 are consumed (ready asserted) but not loaded; VALID is not raised for them.
- bitpos (3 bits) advances by VL[2:0] modulo 8 on each loaded word. VL values 26..31 are forwarded unchanged.
- State IDLE: NEWSLICE -> HDR, clears bitpos and endpend. ENDSLICE is ignored.
- State HDR: an accepted word with HLAST=1 -> COEF.
  - ENDSLICE, or endpend set, while no header word has yet been accepted in this MB -> ALIGN.
  - ENDSLICE arriving mid-header sets endpend.
- State COEF: an accepted word with CLAST=1 -> HDR; if endpend is set -> ALIGN instead. ENDSLICE sets endpend.
- State ALIGN: when slot_free, load VL = 8-bitpos (range 1..8) and VE = 1<<(VL-1): a stop bit followed by zeros. When bitpos=0 this is 0x80 with VL=8. Next state is FLUSH.
- State FLUSH: wait for VALID&&READY on the trailing word, pulse DONE, -> IDLE.
- NEWSLICE outside IDLE is ignored. ENDSLICE coincident with NEWSLICE in IDLE: NEWSLICE wins and endpend is set.
- Simultaneous HLAST acceptance and ENDSLICE in HDR: go to COEF with endpend set.
- RESET mid-operation: the output word is discarded immediately (VALID=0) and all state returns to reset values.
- READY held low indefinitely: source readies stay low after one word is loaded. No word is lost or duplicated.

Optional Feature:
- Macro BITSCHED_BITCOUNT_EN.
- Defined: SLICEBITS counts VL of every loaded word, including the trailing word. It clears on accepted NEWSLICE and saturates at 0xFFFFFFFF. It is valid and stable from DONE until the next NEWSLICE.
- Undefined: SLICEBITS is tied to 0 and no counter logic is generated.

Test Plan:
- NEWSLICE; header words VL=5,3 (HLAST on second); cavlc word VL=9 with CLAST; ENDSLICE; READY=1 -> output order 5,3,9; bitpos=1; trailing word VE=0x40, VL=7; DONE one cycle after its transfer; SLICEBITS=24.
- Cavlc word presented while in HDR -> CREADY=0 until HLAST accepted; header word presented in COEF -> HREADY=0 until CLAST accepted.
- READY=0 for 10 cycles with HVALID=1 -> one word held on VE/VL with VALID=1, HREADY=0; release READY -> words transfer one per cycle, none lost.
- ENDSLICE mid-COEF -> remaining cavlc words through CLAST are forwarded before the trailing word. Total bits 16 gives trailing VE=0x80, VL=8.
- VL=0 header word with HLAST -> no VALID pulse; state moves to COEF.
- RESET asserted while VALID=1 and in COEF -> VALID, BUSY drop asynchronously; after release NEWSLICE restarts at HDR with bitpos=0.
